// File: rtl/data_buf_writer_if.sv
// Byte-stream input and buffer write-port signals of the capture buffer writer.
// master: the writer (consumes bytes, drives the buffer write port).
// slave:  the environment (supplies bytes, observes the write port).
interface data_buf_writer_if;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [11:0] o_wraddress;
  logic [31:0] o_data;
  logic        o_wren;

  modport master (
    input  i_data, i_valid,
    output o_ready, o_wraddress, o_data, o_wren
  );

  modport slave (
    output i_data, i_valid,
    input  o_ready, o_wraddress, o_data, o_wren
  );
endinterface

// File: rtl/data_buf_writer.sv
// Packs a byte stream into 32-bit words for the 4096x32 capture buffer.
// Byte n of a frame lands in lane n[1:0] of word n[13:2], so the buffer's
// byte read port returns byte n at rdaddress = n.
//
// state | meaning
// IDLE  | waiting for i_start; bytes are dropped
// FILL  | accepting bytes, one word written per 4 bytes
// FLUSH | write cycle for a final partial word (padded with FILL_BYTE)
// DONE  | one-cycle o_done pulse, then back to IDLE
module data_buf_writer #(
  parameter logic [7:0] FILL_BYTE = 8'h00,
  parameter int         MAX_BYTES = 16384
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [14:0]            i_len,
  data_buf_writer_if.master      bus,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [14:0]            o_byte_cnt,
  output logic                   o_drop
);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

  localparam logic [14:0] MAX_LEN = 15'(MAX_BYTES);

  state_t      state_q, state_d;
  logic [14:0] len_q, len_d;
  logic [14:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] pack_q, pack_d;
  logic [31:0] data_q, data_d;
  logic [11:0] addr_q, addr_d;
  logic        wren_q, wren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        drop_q, drop_d;

  logic [1:0]  lane;
  logic        accept;
  logic        last;

  assign lane   = byte_cnt_q[1:0];
  assign accept = (state_q == FILL) && bus.i_valid;
  assign last   = (byte_cnt_q + 15'd1) == len_q;

  // Next-state, packing and registered-output computation.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    data_d     = data_q;
    addr_d     = addr_q;
    wren_d     = 1'b0;
    drop_d     = drop_q;

    // Any byte offered outside FILL is lost; an honoured start below wins.
    if (bus.i_valid && (state_q != FILL)) drop_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          drop_d     = 1'b0;
          byte_cnt_d = '0;
          pack_d     = {4{FILL_BYTE}};
          if (i_len == 15'd0) begin
            state_d = DONE;
          end else begin
            len_d   = (i_len > MAX_LEN) ? MAX_LEN : i_len;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          // Lane 0 pre-pads the upper lanes so a partial word is ready as-is.
          if (lane == 2'd0) pack_d = {{3{FILL_BYTE}}, bus.i_data};
          else              pack_d[{lane, 3'b000} +: 8] = bus.i_data;
          byte_cnt_d = byte_cnt_q + 15'd1;
          if ((lane == 2'd3) || last) begin
            wren_d = 1'b1;
            data_d = pack_d;
            addr_d = byte_cnt_q[13:2];
          end
          if (last) state_d = (lane == 2'd3) ? DONE : FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == FILL) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      wren_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      wren_q     <= wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.o_ready       = (state_q == FILL);
  assign bus.o_wraddress   = addr_q;
  assign bus.o_data        = data_q;
  assign bus.o_wren        = wren_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_byte_cnt        = byte_cnt_q;
  assign o_drop            = drop_q;

endmodule

// File: tb/tb_data_buf_writer.sv
// Bench for data_buf_writer: table of directed frames, hand-written reset and
// mid-frame start sequences, and random frames, all checked against a
// frame-level model (bytes -> words, expected write/done cycles).
module tb_data_buf_writer;
  localparam logic [7:0] FILL_BYTE = 8'h00;
  localparam int         MAX_BYTES = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [14:0] i_len;
  logic        o_busy, o_done, o_drop;
  logic [14:0] o_byte_cnt;

  data_buf_writer_if bus ();

  data_buf_writer #(.FILL_BYTE(FILL_BYTE), .MAX_BYTES(MAX_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_len      (i_len),
    .bus        (bus),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_byte_cnt (o_byte_cnt),
    .o_drop     (o_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t        wr_q[$];
  int         done_q[$];
  logic [7:0] stim_q[$];

  // Observe the write port and done pulse away from the active edge.
  always @(negedge clk) begin
    if (bus.o_wren) wr_q.push_back('{bus.o_wraddress, bus.o_data, cyc});
    if (o_done)     done_q.push_back(cyc);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One frame: start pulse, then 'offers' valid bytes from stim_q spread per
  // gap mode (0 continuous, 1 every other cycle, 2 random), then check.
  task automatic run_frame(input int len, input int offers, input int gap,
                           input bit mid_start, input string name);
    int         leff, acc, off, t, extra, ready_bad, start_cyc, nw, exp_done;
    int         acc_cyc[$];
    logic [7:0] acc_byte[$];
    bit         v;
    leff = (len > MAX_BYTES) ? MAX_BYTES : len;
    wr_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    i_start = 1'b1; i_len = 15'(len); bus.i_valid = 1'b0;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    acc = 0; off = 0; t = 0; extra = 0; ready_bad = 0;
    while (off < offers) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (t % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      i_start = (mid_start && acc == 2);
      if (mid_start && acc == 2) i_len = 15'd2;
      if (bus.o_ready !== (acc < leff)) ready_bad++;
      bus.i_valid = v;
      bus.i_data  = v ? stim_q[off] : 8'h5A;
      if (v) begin
        if (acc < leff) begin
          acc_cyc.push_back(cyc);
          acc_byte.push_back(stim_q[off]);
          acc++;
        end else begin
          extra++;
        end
        off++;
      end
      t++;
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    i_start     = 1'b0;
    for (int k = 0; k < 10 && done_q.size() == 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;

    chk({name, " ready"}, 64'(ready_bad), 64'd0);
    nw = (leff + 3) / 4;
    chk({name, " wr_count"}, 64'(wr_q.size()), 64'(nw));
    for (int w = 0; w < nw && w < wr_q.size(); w++) begin
      logic [31:0] word;
      int          lastb;
      word = {4{FILL_BYTE}};
      for (int j = 0; j < 4; j++)
        if (4 * w + j < leff) word[8*j +: 8] = acc_byte[4*w+j];
      lastb = (4 * w + 3 < leff) ? 4 * w + 3 : leff - 1;
      chk($sformatf("%s wr%0d addr/data/cyc", name, w),
          {wr_q[w].addr, wr_q[w].data, 20'(wr_q[w].cyc)},
          {12'(w), word, 20'(acc_cyc[lastb] + 1)});
    end
    if (leff == 0) exp_done = start_cyc + 1;
    else           exp_done = acc_cyc[leff-1] + 1 + ((leff % 4 == 0) ? 0 : 1);
    chk({name, " done_count"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) chk({name, " done_cyc"}, 64'(done_q[0]), 64'(exp_done));
    chk({name, " byte_cnt"}, 64'(o_byte_cnt), 64'(leff));
    chk({name, " drop"}, 64'(o_drop), 64'(extra > 0));
    chk({name, " idle_outs"}, {60'd0, o_busy, bus.o_ready, o_done, bus.o_wren}, 64'd0);
  endtask

  typedef struct {
    int          len;
    int          offers;
    int          gap;
    logic [7:0]  base;
    logic [7:0]  step;
    int          exp_words;
    int          exp_cnt;
    bit          exp_drop;
    logic [11:0] exp_last_addr;
    logic [31:0] exp_last_word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8,     8,     0, 8'h01, 8'h01, 2,    8,     1'b0, 12'd1,    32'h08070605};
    vecs[1] = '{6,     6,     0, 8'hAA, 8'h11, 2,    6,     1'b0, 12'd1,    32'h0000FFEE};
    vecs[2] = '{5,     5,     1, 8'h10, 8'h01, 2,    5,     1'b0, 12'd1,    32'h00000014};
    vecs[3] = '{0,     0,     0, 8'h00, 8'h01, 0,    0,     1'b0, 12'd0,    32'h00000000};
    vecs[4] = '{4,     6,     0, 8'h20, 8'h01, 1,    4,     1'b1, 12'd0,    32'h23222120};
    vecs[5] = '{1,     1,     2, 8'h7F, 8'h01, 1,    1,     1'b0, 12'd0,    32'h0000007F};
    vecs[6] = '{3,     3,     0, 8'h30, 8'h01, 1,    3,     1'b0, 12'd0,    32'h00323130};
    vecs[7] = '{20000, 16386, 0, 8'h00, 8'h01, 4096, 16384, 1'b1, 12'd4095, 32'hFFFEFDFC};

    rst_n = 1'b0; i_start = 1'b0; i_len = '0;
    bus.i_valid = 1'b0; bus.i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", {o_wren_bits(), 31'd0},  64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      stim_q.delete();
      for (int b = 0; b < vecs[i].offers; b++)
        stim_q.push_back(8'(vecs[i].base + 8'(b) * vecs[i].step));
      run_frame(vecs[i].len, vecs[i].offers, vecs[i].gap, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_words", i), 64'(wr_q.size()), 64'(vecs[i].exp_words));
      chk($sformatf("vec%0d tbl_cnt", i), 64'(o_byte_cnt), 64'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d tbl_drop", i), 64'(o_drop), 64'(vecs[i].exp_drop));
      if (vecs[i].exp_words > 0 && wr_q.size() > 0)
        chk($sformatf("vec%0d tbl_last", i), {20'd0, wr_q[$].addr, wr_q[$].data},
            {20'd0, vecs[i].exp_last_addr, vecs[i].exp_last_word});
    end

    // Start pulse while filling must not restart or shorten the frame.
    stim_q.delete();
    for (int b = 0; b < 8; b++) stim_q.push_back(8'(8'hC0 + b));
    run_frame(8, 8, 0, 1'b1, "mid_start");

    // Reset after 3 bytes of an 8-byte frame abandons it.
    @(posedge clk); #1;
    i_start = 1'b1; i_len = 15'd8;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.i_valid = 1'b1; bus.i_data = 8'(8'h90 + b);
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset outs", {o_wren_bits(), 31'd0}, 64'd0);
    rst_n = 1'b1;
    wr_q.delete();
    done_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("midreset no_wr", 64'(wr_q.size()), 64'd0);
    chk("midreset no_done", 64'(done_q.size()), 64'd0);
    stim_q.delete();
    for (int b = 0; b < 4; b++) stim_q.push_back(8'(8'hE0 + b));
    run_frame(4, 4, 0, 1'b0, "post_reset");

    // Random frames.
    for (int r = 0; r < 30; r++) begin
      int len, offers;
      len    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      offers = len + int'($urandom_range(0, 3));
      stim_q.delete();
      for (int b = 0; b < offers; b++) stim_q.push_back(8'($urandom));
      run_frame(len, offers, int'($urandom_range(0, 2)), 1'b0, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // All DUT outputs concatenated (33 bits used); zero after reset.
  function automatic logic [32:0] o_wren_bits();
    return {bus.o_wren, o_done, o_busy, o_drop, bus.o_ready,
            bus.o_wraddress, 1'b0, o_byte_cnt} | {1'b0, (|bus.o_data) ? 32'h1 : 32'h0};
  endfunction

endmodule
